softex_fp_glob_argminmax: RTL and testbench
===========================================

Name: softex_fp_glob_argminmax

Overview:
Multi-channel successor to the single-accumulator global min/max tracker. Keeps NUM_CH independent running min/max accumulators, each with its own mode and element counter. Reports the winning element's global index (argmin/argmax) alongside the value. Fully valid/ready-handshaked with one registered output stage, so it can sit between the softex streamer and the datapath when several rows are interleaved.

Parameters:
FPFORMAT, FPFORMAT_IN, floating-point format of vector elements; WIDTH = fp_width(FPFORMAT).
VECT_WIDTH, 4, lanes per input beat.
NUM_CH, 4, number of independent channels (>=1); CH_W = max(1, $clog2(NUM_CH)).
IDX_WIDTH, 16, width of per-channel element counter and arg output.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  sync global clear: all channels, output stage
enable_i  in  1  global enable; 0 freezes all state, ready_o=0
ch_clear_i  in  1  reinitialise channel ch_i, latch operation_i as its mode
operation_i  in  min_max_mode_t  mode loaded on ch_clear_i
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i & ready_o
ch_i  in  CH_W  channel of input beat / ch_clear_i target
strb_i  in  VECT_WIDTH  lane strobes
vect_i  in  VECT_WIDTH x WIDTH  input lanes
last_i  in  1  last beat of this channel's row
valid_o  out  1  output stage valid
ready_i  in  1  downstream ready
ch_o  out  CH_W  channel of result
cur_minmax_o  out  WIDTH  channel value before this beat
new_minmax_o  out  WIDTH  channel value after this beat
new_flg_o  out  1  this beat strictly improved the channel
arg_o  out  IDX_WIDTH  global element index of new_minmax_o
last_o  out  1  registered last_i; row result final

Behaviour:
- Accept = valid_i & ready_o. ready_o = enable_i & ~clear_i & (~valid_o | ready_i). Latency: 1 cycle, accept -> valid_o.
- Per-channel state: acc_q (WIDTH), arg_q, base_q (element counter), mode_q, empty_q.
- Reset/init: acc_q = -inf for MAX, +inf for MIN. Reset mode MAX, arg_q 0, base_q 0, empty_q 1.
- Output reset: valid_o 0; ch_o, cur/new_minmax_o, arg_o, new_flg_o, last_o all 0.
- Lane reduction is combinational over strobed, non-NaN lanes: extreme value and lowest lane index achieving it. Ties keep the lower lane.
- Candidate index = base_q + lane.
- Update on accept: new_flg = any valid lane & (candidate strictly GT (MAX) / LT (MIN) acc_q). Equal values keep the older arg.
- If new_flg: acc_q <= candidate, arg_q <= index.
- base_q += VECT_WIDTH on every accepted beat, saturating at 2^IDX_WIDTH-1. Index is also saturated.
- Output stage loads {ch, old acc, updated acc, arg, new_flg, last} on accept. It holds while valid_o & ~ready_i.
- Fully masked beat (strb_i=0): accepted, base_q advances, new_flg_o=0, value unchanged.
- On accepted beat with last_i: output carries the final value. Afterwards the channel reinitialises (same mode; acc, arg, base, empty reset).
- ch_clear_i with accept on the same channel, same cycle: clear first, then the beat is evaluated against the init value using the new mode.
- ch_clear_i on a different channel: independent.
- ch_clear_i does not need valid_i and is ignored when enable_i=0.
- clear_i has highest priority: all channels reinitialise to MAX mode, valid_o<=0, and an in-flight output is dropped.
- ch_i >= NUM_CH: beat accepted and discarded. No output, no state change.
- Asynchronous reset mid-operation: everything returns to reset values immediately.

Optional Feature:
SOFTEX_ARGMINMAX_NAN_PROP_EN.
- Defined: any strobed NaN lane makes the channel sticky-NaN. acc_q becomes canonical qNaN, new_flg_o=1 on that beat, arg_o = first NaN index.
- While sticky, later beats set new_flg_o=0 and the value stays qNaN until ch_clear_i, last beat reinit, or clear_i.
- Undefined: NaN lanes are treated as unstrobed.

Test Plan:
- FP16, MAX, ch0, beats {0x3C00,0x4000,0x3C00,0x3C00} then {0x4200,0,0,0} last -> out1 new=0x4000 arg=1 flg=1; out2 cur=0x4000 new=0x4200 arg=4 last_o=1.
- ch_clear ch1 MIN; interleave ch0/ch1 beats; ch1 {0x4000,0xBC00,..} -> ch1 new=0xBC00 arg=1; ch0 value unaffected.
- Tie: MAX beats {0x4000,0x4000,0,0} then {0x4000,...} -> arg_o=0, second beat flg=0.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1 -> ready_o=0, outputs stable. After release, next beat accepted one cycle later with no loss.
- Simultaneous ch_clear_i(MIN)+beat {0x4200,0x3C00,...} on ch2 -> new=0x3C00 arg=1 flg=1; clear_i mid-stream -> valid_o=0 next cycle, ch0 acc=0xFC00.
- NaN lane 0x7E00 at lane 2: without macro -> ignored. With SOFTEX_ARGMINMAX_NAN_PROP_EN -> new=0x7E00 arg=2, sticky until ch_clear.

Source files
------------

// File: rtl/softex_fp_glob_argminmax.sv
// softex_fp_glob_argminmax
//   Multi-channel running min/max tracker with argmin/argmax. NUM_CH
//   independent accumulators, each with its own mode and element counter.
//   One registered valid/ready output stage (accept -> valid_o is 1 cycle).
//
//   FPFORMAT: 0=FP32 1=FP64 2=FP16 3=FP8(e5m2) 4=BF16.
//   operation_i: 0 = MAX, 1 = MIN.
//   Optional macro SOFTEX_ARGMINMAX_NAN_PROP_EN: a strobed NaN lane turns the
//   channel sticky qNaN. Without it NaN lanes are treated as unstrobed.
//
//   Ports
//     clk_i, rst_ni          clock, async active-low reset
//     clear_i                sync clear of all channels and the output stage
//     enable_i               global enable (0 freezes state, ready_o=0)
//     ch_clear_i/operation_i reinit channel ch_i, load its mode
//     valid_i/ready_o        input handshake; ch_i, strb_i, vect_i, last_i
//     valid_o/ready_i        output handshake; ch_o, cur/new_minmax_o,
//                            new_flg_o, arg_o, last_o

module softex_fp_glob_argminmax_lane #(
  parameter int unsigned EXP_BITS = 5,
  parameter int unsigned MAN_BITS = 10
) (
  input  logic [EXP_BITS+MAN_BITS:0] val_i,
  output logic                       nan_o,
  output logic [EXP_BITS+MAN_BITS:0] key_o
);
  localparam int unsigned W = 1 + EXP_BITS + MAN_BITS;

  // key_o orders like an unsigned integer; -0 folds onto +0 so they tie
  always_comb begin
    nan_o = (&val_i[W-2:MAN_BITS]) & (|val_i[MAN_BITS-1:0]);
    if (~|val_i[W-2:0])  key_o = {1'b1, {(W-1){1'b0}}};
    else if (val_i[W-1]) key_o = ~val_i;
    else                 key_o = {1'b1, val_i[W-2:0]};
  end
endmodule

module softex_fp_glob_argminmax #(
  parameter int unsigned FPFORMAT   = 2,
  parameter int unsigned VECT_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IDX_WIDTH  = 16,
  localparam int unsigned EXP_BITS  = (FPFORMAT == 1) ? 11 :
                                      (FPFORMAT == 2 || FPFORMAT == 3) ? 5 : 8,
  localparam int unsigned MAN_BITS  = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 :
                                      (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2 : 7,
  localparam int unsigned WIDTH     = 1 + EXP_BITS + MAN_BITS,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic                                enable_i,
  input  logic                                ch_clear_i,
  input  logic                                operation_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [CH_W-1:0]                     ch_i,
  input  logic [VECT_WIDTH-1:0]               strb_i,
  input  logic [VECT_WIDTH-1:0][WIDTH-1:0]    vect_i,
  input  logic                                last_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [CH_W-1:0]                     ch_o,
  output logic [WIDTH-1:0]                    cur_minmax_o,
  output logic [WIDTH-1:0]                    new_minmax_o,
  output logic                                new_flg_o,
  output logic [IDX_WIDTH-1:0]                arg_o,
  output logic                                last_o
);
  localparam logic MODE_MAX = 1'b0;
  localparam int unsigned LW = (VECT_WIDTH > 1) ? $clog2(VECT_WIDTH) : 1;

  function automatic logic [WIDTH-1:0] inf_val(logic min);
    return {~min, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
  endfunction

  function automatic logic [IDX_WIDTH-1:0] sat_add(logic [IDX_WIDTH-1:0] a,
                                                   logic [IDX_WIDTH:0]   b);
    logic [IDX_WIDTH+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (|s[IDX_WIDTH+1:IDX_WIDTH]) ? {IDX_WIDTH{1'b1}} : s[IDX_WIDTH-1:0];
  endfunction

  // per-channel state
  logic [NUM_CH-1:0][WIDTH-1:0]     acc_q;
  logic [NUM_CH-1:0][IDX_WIDTH-1:0] arg_q, base_q;
  logic [NUM_CH-1:0]                mode_q, empty_q;

  // output stage
  logic                 vld_q, flg_q, last_q;
  logic [CH_W-1:0]      ch_q;
  logic [WIDTH-1:0]     cur_q, new_q;
  logic [IDX_WIDTH-1:0] oarg_q;

  logic ch_ok, accept, beat, chc_hit;
  assign ready_o = enable_i & ~clear_i & (~vld_q | ready_i);
  assign accept  = valid_i & ready_o;
  assign ch_ok   = 32'(ch_i) < NUM_CH;
  assign beat    = accept & ch_ok;
  assign chc_hit = enable_i & ~clear_i & ch_clear_i & ch_ok;

  // selected channel, after a same-cycle ch_clear_i has been applied
  logic                 mode_s, empty_s, mode_e, empty_e;
  logic [WIDTH-1:0]     acc_s, acc_e;
  logic [IDX_WIDTH-1:0] arg_s, base_s, arg_e, base_e;

  always_comb begin
    mode_s  = MODE_MAX;
    empty_s = 1'b1;
    acc_s   = '0;
    arg_s   = '0;
    base_s  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_i == CH_W'(c)) begin
        mode_s  = mode_q[c];
        empty_s = empty_q[c];
        acc_s   = acc_q[c];
        arg_s   = arg_q[c];
        base_s  = base_q[c];
      end
    end
    mode_e  = chc_hit ? operation_i : mode_s;
    empty_e = chc_hit | empty_s;
    acc_e   = empty_e ? inf_val(mode_e) : acc_s;
    arg_e   = chc_hit ? '0 : arg_s;
    base_e  = chc_hit ? '0 : base_s;
  end

  // lane decode; slot VECT_WIDTH decodes the accumulator itself
  logic [VECT_WIDTH:0][WIDTH-1:0] dec_val, dec_key;
  logic [VECT_WIDTH:0]            dec_nan;
  assign dec_val = {acc_e, vect_i};

  for (genvar l = 0; l <= VECT_WIDTH; l++) begin : g_lane
    softex_fp_glob_argminmax_lane #(.EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS)) u_lane (
      .val_i (dec_val[l]),
      .nan_o (dec_nan[l]),
      .key_o (dec_key[l])
    );
  end

  // Reduction seeded with the accumulator: a lane wins only if strictly
  // better than everything before it, so ties keep the older arg and then
  // the lower lane.
  logic                 red_vld, red_acc;
  logic [WIDTH-1:0]     red_key, red_val, new_acc;
  logic [LW-1:0]        red_lane;
  logic [IDX_WIDTH-1:0] new_arg, base_nxt;
  logic                 new_flg;

  always_comb begin
    red_vld  = ~dec_nan[VECT_WIDTH];
    red_key  = dec_key[VECT_WIDTH];
    red_val  = acc_e;
    red_lane = '0;
    red_acc  = 1'b1;
    for (int l = 0; l < VECT_WIDTH; l++) begin
      if (strb_i[l] & ~dec_nan[l] &
          (~red_vld | (mode_e ? (dec_key[l] < red_key) : (dec_key[l] > red_key)))) begin
        red_vld  = 1'b1;
        red_key  = dec_key[l];
        red_val  = vect_i[l];
        red_lane = LW'(l);
        red_acc  = 1'b0;
      end
    end
    new_flg = ~red_acc;
    new_acc = red_val;
    new_arg = red_acc ? arg_e : sat_add(base_e, (IDX_WIDTH+1)'(red_lane));
`ifdef SOFTEX_ARGMINMAX_NAN_PROP_EN
    begin
      logic          nan_any;
      logic [LW-1:0] nan_lane;
      nan_any  = 1'b0;
      nan_lane = '0;
      for (int l = VECT_WIDTH - 1; l >= 0; l--) begin
        if (strb_i[l] & dec_nan[l]) begin
          nan_any  = 1'b1;
          nan_lane = LW'(l);
        end
      end
      // accumulator can only hold NaN once sticky
      if (dec_nan[VECT_WIDTH]) begin
        new_flg = 1'b0;
        new_acc = acc_e;
        new_arg = arg_e;
      end else if (nan_any) begin
        new_flg = 1'b1;
        new_acc = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
        new_arg = sat_add(base_e, (IDX_WIDTH+1)'(nan_lane));
      end
    end
`endif
    base_nxt = sat_add(base_e, (IDX_WIDTH+1)'(VECT_WIDTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= {NUM_CH{inf_val(MODE_MAX)}};
      arg_q   <= '0;
      base_q  <= '0;
      mode_q  <= {NUM_CH{MODE_MAX}};
      empty_q <= '1;
    end else if (clear_i) begin
      acc_q   <= {NUM_CH{inf_val(MODE_MAX)}};
      arg_q   <= '0;
      base_q  <= '0;
      mode_q  <= {NUM_CH{MODE_MAX}};
      empty_q <= '1;
    end else if (enable_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((beat & last_i) | (chc_hit & ~beat)) begin
          // row finished or explicit clear: back to init in the chosen mode
          if (ch_i == CH_W'(c)) begin
            acc_q[c]   <= inf_val(mode_e);
            arg_q[c]   <= '0;
            base_q[c]  <= '0;
            mode_q[c]  <= mode_e;
            empty_q[c] <= 1'b1;
          end
        end else if (beat && ch_i == CH_W'(c)) begin
          acc_q[c]   <= new_acc;
          arg_q[c]   <= new_arg;
          base_q[c]  <= base_nxt;
          mode_q[c]  <= mode_e;
          empty_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      ch_q   <= '0;
      cur_q  <= '0;
      new_q  <= '0;
      oarg_q <= '0;
      flg_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (clear_i) begin
      vld_q <= 1'b0;
    end else if (enable_i) begin
      if (beat) begin
        vld_q  <= 1'b1;
        ch_q   <= ch_i;
        cur_q  <= acc_e;
        new_q  <= new_acc;
        oarg_q <= new_arg;
        flg_q  <= new_flg;
        last_q <= last_i;
      end else if (ready_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign valid_o      = vld_q;
  assign ch_o         = ch_q;
  assign cur_minmax_o = cur_q;
  assign new_minmax_o = new_q;
  assign arg_o        = oarg_q;
  assign new_flg_o    = flg_q;
  assign last_o       = last_q;
endmodule

// File: tb/tb_softex_fp_glob_argminmax.sv
module tb_softex_fp_glob_argminmax;
  localparam int VW = 4, NCH = 3, IW = 4, W = 16, CW = 2;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, en = 1'b1, chclr = 1'b0;
  logic op = 1'b0, vin = 1'b0, rin = 1'b1, lst = 1'b0;
  logic [CW-1:0] chi = '0;
  logic [VW-1:0] strb = '0;
  logic [VW-1:0][W-1:0] vect = '0;
  logic rdy, vout, flg, lsto;
  logic [CW-1:0] cho;
  logic [W-1:0] cur, nw;
  logic [IW-1:0] arg;

  softex_fp_glob_argminmax #(.FPFORMAT(2), .VECT_WIDTH(VW), .NUM_CH(NCH), .IDX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(en), .ch_clear_i(chclr),
    .operation_i(op), .valid_i(vin), .ready_o(rdy), .ch_i(chi), .strb_i(strb),
    .vect_i(vect), .last_i(lst), .valid_o(vout), .ready_i(rin), .ch_o(cho),
    .cur_minmax_o(cur), .new_minmax_o(nw), .new_flg_o(flg), .arg_o(arg), .last_o(lsto)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  cur;
    logic [W-1:0]  nw;
    logic [IW-1:0] arg;
    logic          flg;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int total = 0, bad = 0;

  // monitor: a transfer happens at the posedge after a negedge with valid & ready
  always @(negedge clk) begin
    if (rst_n && vout && rin) begin
      mon_a = '{cho, cur, nw, arg, flg, lsto};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h", mon_a);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL out ch/cur/new/arg/flg/last got=%0d/%h/%h/%0d/%b/%b exp=%0d/%h/%h/%0d/%b/%b",
                   mon_a.ch, mon_a.cur, mon_a.nw, mon_a.arg, mon_a.flg, mon_a.last,
                   mon_e.ch, mon_e.cur, mon_e.nw, mon_e.arg, mon_e.flg, mon_e.last);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // one input beat; vector is {lane3,lane2,lane1,lane0}
  task automatic send(input logic [CW-1:0] c, input logic clr, input logic o,
                      input logic [VW-1:0] s, input logic [63:0] v, input logic l,
                      input logic push, input logic [W-1:0] ecur, input logic [W-1:0] enew,
                      input logic [IW-1:0] earg, input logic eflg);
    int n;
    @(posedge clk); #1;
    chi = c; chclr = clr; op = o; strb = s; vect = v; lst = l; vin = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL send_timeout ch=%0d got=ready0 exp=ready1", c);
    end else if (push) begin
      sb.push_back('{c, ecur, enew, earg, eflg, l});
    end
    @(posedge clk); #1;
    vin = 1'b0; chclr = 1'b0; lst = 1'b0;
  endtask

  task automatic chan_clear(input logic [CW-1:0] c, input logic o);
    @(posedge clk); #1;
    chi = c; op = o; chclr = 1'b1;
    @(posedge clk); #1;
    chclr = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_valid", 32'(vout), 0);
    chk("rst_outs", {cho, cur, nw, arg, flg, lsto}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 1);
    en = 1'b0;
    @(negedge clk);
    chk("disable_ready", 32'(rdy), 0);
    en = 1'b1;

    // basic MAX on ch0, then last
    send(0, 0, 0, 4'hF, {16'h3C00, 16'h3C00, 16'h4000, 16'h3C00}, 0, 1, 16'hFC00, 16'h4000, 1, 1);
    send(0, 0, 0, 4'hF, {16'h0000, 16'h0000, 16'h0000, 16'h4200}, 1, 1, 16'h4000, 16'h4200, 4, 1);

    // ch1 MIN interleaved with ch0
    chan_clear(1, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h3C00}, 0, 1, 16'hFC00, 16'h3C00, 0, 1);
    send(1, 0, 0, 4'h3, {32'h0, 16'hBC00, 16'h4000}, 0, 1, 16'h7C00, 16'hBC00, 1, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h4000}, 0, 1, 16'h3C00, 16'h4000, 4, 1);
    send(1, 0, 0, 4'h0, {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 0, 1, 16'hBC00, 16'hBC00, 1, 0);
    send(1, 0, 0, 4'h1, {48'h0, 16'hC000}, 0, 1, 16'hBC00, 16'hC000, 8, 1);

    // backpressure
    @(posedge clk); #1 rin = 1'b0;
    send(0, 0, 0, 4'h1, {48'h0, 16'h4200}, 0, 1, 16'h4000, 16'h4200, 8, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(rdy), 0);
      chk("stall_hold", {15'(0), vout, nw}, {15'(0), 1'b1, 16'h4200});
    end
    @(posedge clk); #1 rin = 1'b1;
    send(0, 0, 0, 4'h1, {48'h0, 16'h4400}, 0, 1, 16'h4200, 16'h4400, 12, 1);

    // ch_clear + beat same cycle, then tie handling
    send(2, 1, 1, 4'h3, {32'h0, 16'h3C00, 16'h4200}, 0, 1, 16'h7C00, 16'h3C00, 1, 1);
    send(2, 1, 0, 4'h3, {32'h0, 16'h4000, 16'h4000}, 0, 1, 16'hFC00, 16'h4000, 0, 1);
    send(2, 0, 0, 4'h1, {48'h0, 16'h4000}, 0, 1, 16'h4000, 16'h4000, 0, 0);

    // out-of-range channel: accepted, no output
    send(3, 0, 0, 4'hF, {16'h7000, 16'h7000, 16'h7000, 16'h7000}, 0, 0, 0, 0, 0, 0);

    // global clear drops the in-flight output
    @(posedge clk); #1 rin = 1'b0;
    send(0, 0, 0, 4'h1, {48'h0, 16'h4500}, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_ready", 32'(rdy), 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_valid", 32'(vout), 0);
    @(posedge clk); #1 rin = 1'b1;
    send(0, 0, 0, 4'h0, {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 0, 1, 16'hFC00, 16'hFC00, 0, 0);
    send(1, 0, 0, 4'h1, {48'h0, 16'h4000}, 0, 1, 16'hFC00, 16'h4000, 0, 1);

    // NaN lane at lane 2
`ifdef SOFTEX_ARGMINMAX_NAN_PROP_EN
    send(2, 1, 0, 4'h5, {16'h0, 16'h7E00, 16'h0, 16'h3C00}, 0, 1, 16'hFC00, 16'h7E00, 2, 1);
    send(2, 0, 0, 4'h1, {48'h0, 16'h4400}, 0, 1, 16'h7E00, 16'h7E00, 2, 0);
`else
    send(2, 1, 0, 4'h5, {16'h0, 16'h7E00, 16'h0, 16'h3C00}, 0, 1, 16'hFC00, 16'h3C00, 0, 1);
    send(2, 0, 0, 4'h1, {48'h0, 16'h4400}, 0, 1, 16'h3C00, 16'h4400, 4, 1);
`endif
    send(2, 1, 0, 4'h1, {48'h0, 16'h3C00}, 0, 1, 16'hFC00, 16'h3C00, 0, 1);

    // index saturation (IDX_WIDTH=4 -> max 15)
    send(0, 1, 0, 4'h1, {48'h0, 16'h3C00}, 0, 1, 16'hFC00, 16'h3C00, 0, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h4000}, 0, 1, 16'h3C00, 16'h4000, 4, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h4200}, 0, 1, 16'h4000, 16'h4200, 8, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h4400}, 0, 1, 16'h4200, 16'h4400, 12, 1);
    send(0, 0, 0, 4'h8, {16'h4500, 48'h0}, 0, 1, 16'h4400, 16'h4500, 15, 1);
    send(0, 0, 0, 4'h1, {48'h0, 16'h4600}, 1, 1, 16'h4500, 16'h4600, 15, 1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
